// File: rtl/ex_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//  master : pipeline side, presents ID-stage info and mem_busy, consumes stalls/selects/stats
//  slave  : controller side
interface ex_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             mem_busy;
    logic             stall_pc;
    logic             stall_ifid;
    logic             bubble_idex;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] lu_hazards;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, mem_busy,
        input  stall_pc, stall_ifid, bubble_idex, fwd_a, fwd_b, stall_cycles, lu_hazards
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, mem_busy,
        output stall_pc, stall_ifid, bubble_idex, fwd_a, fwd_b, stall_cycles, lu_hazards
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Hazard/sequencing controller around the EX ALU of a 5-stage pipeline.
// Tracks shadow destination info for EX/MEM/WB, inserts load-use bubbles,
// freezes on memory wait, and produces registered forwarding selects plus
// saturating stall statistics.
//  clk, reset : clock and asynchronous active-low reset
//  bus        : slave side of ex_hazard_ctrl_if (ID info, mem_busy in; stalls,
//               fwd_a/fwd_b, stall_cycles, lu_hazards out)
module ex_hazard_ctrl #(
    parameter int unsigned LU_BUBBLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    ex_hazard_ctrl_if.slave bus
);
    localparam int unsigned BCNT_W = 2;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b10;
    localparam logic [1:0] FWD_MEM = 2'b01;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } shadow_t;

    logic [1:0]        state, state_d;
    logic [1:0]        saved_state, saved_state_d;
    logic [BCNT_W-1:0] bub_cnt, bub_cnt_d;
    shadow_t           s_ex, s_mem, s_wb;
    logic [1:0]        fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0]  stall_cnt_q, lu_cnt_q;

    logic      use_rs, use_rt, lu_hit;
    logic      advance, bubble, stall, lu_inc;
    logic [1:0] eff_state;
    shadow_t   id_info;

    function automatic logic prod_match(input shadow_t s, input logic [4:0] x);
        return s.valid && s.reg_write && (s.rd != 5'd0) && (s.rd == x);
    endfunction

    // Youngest producer wins; a load in EX never forwards (it stalls instead).
    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] x,
                                           input shadow_t ex, input shadow_t mem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used) begin
            if (prod_match(ex, x) && !ex.mem_read) begin
                sel = FWD_EX;
            end else if (prod_match(mem, x)) begin
                sel = FWD_MEM;
            end
        end
        return sel;
    endfunction

    // Source-use decode and load-use detection against S_EX
    always_comb begin
        use_rs = bus.id_valid && ((bus.id_opcode == OP_ADD) || (bus.id_opcode == OP_LW) ||
                                  (bus.id_opcode == OP_SW));
        use_rt = bus.id_valid && ((bus.id_opcode == OP_ADD) || (bus.id_opcode == OP_SW));
        lu_hit = s_ex.mem_read && ((use_rs && prod_match(s_ex, bus.id_rs)) ||
                                   (use_rt && prod_match(s_ex, bus.id_rt)));
        id_info.valid     = bus.id_valid;
        id_info.rd        = bus.id_rd;
        id_info.reg_write = bus.id_reg_write;
        id_info.mem_read  = bus.id_mem_read;
    end

    // Leaving MEM_WAIT behaves as the saved state in the release cycle, so the
    // freeze lasts exactly as long as mem_busy.
    assign eff_state = (state == ST_MEM_WAIT) ? saved_state : state;

    // Next-state and control decode
    always_comb begin
        state_d       = state;
        saved_state_d = saved_state;
        bub_cnt_d     = bub_cnt;
        advance       = 1'b0;
        bubble        = 1'b0;
        stall         = 1'b0;
        lu_inc        = 1'b0;
        if (bus.mem_busy) begin
            stall   = 1'b1;
            state_d = ST_MEM_WAIT;
            if (state != ST_MEM_WAIT) begin
                saved_state_d = state;
            end
        end else begin
            case (eff_state)
                ST_LU_STALL: begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    advance = 1'b1;
                    if (bub_cnt == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d   = ST_LU_STALL;
                        bub_cnt_d = bub_cnt - BCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    advance = 1'b1;
                    if (lu_hit) begin
                        // The detection cycle itself issues the first bubble.
                        stall  = 1'b1;
                        bubble = 1'b1;
                        lu_inc = 1'b1;
                        if (LU_BUBBLES > 1) begin
                            state_d   = ST_LU_STALL;
                            bub_cnt_d = BCNT_W'(LU_BUBBLES - 2);
                        end
                    end
                end
            endcase
        end
    end

    // State, shadow pipe, forwarding selects and statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            bub_cnt     <= '0;
            s_ex        <= '0;
            s_mem       <= '0;
            s_wb        <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            state       <= state_d;
            saved_state <= saved_state_d;
            bub_cnt     <= bub_cnt_d;
            if (advance) begin
                s_wb  <= s_mem;
                s_mem <= s_ex;
                s_ex  <= bubble ? shadow_t'('0) : id_info;
                if (bubble) begin
                    fwd_a_q <= FWD_RF;
                    fwd_b_q <= FWD_RF;
                end else begin
                    fwd_a_q <= fwd_sel(use_rs, bus.id_rs, s_ex, s_mem);
                    fwd_b_q <= fwd_sel(use_rt, bus.id_rt, s_ex, s_mem);
                end
            end
            if (stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (lu_inc && (lu_cnt_q != CNT_MAX)) begin
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            end
        end
    end

    // Stall controls follow the hazard in the same cycle; held low during reset.
    assign bus.stall_pc     = reset && stall;
    assign bus.stall_ifid   = reset && stall;
    assign bus.bubble_idex  = reset && bubble;
    assign bus.fwd_a        = fwd_a_q;
    assign bus.fwd_b        = fwd_b_q;
    assign bus.stall_cycles = stall_cnt_q;
    assign bus.lu_hazards   = lu_cnt_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: dut_a uses defaults (LU_BUBBLES=1, CNT_W=16),
// dut_b uses LU_BUBBLES=2, CNT_W=4; both see the same stimulus.
module tb_ex_hazard_ctrl;
    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_reg_write, id_mem_read, mem_busy;
    int         total;
    int         bad;

    ex_hazard_ctrl_if #(.CNT_W(16)) ifa ();
    ex_hazard_ctrl_if #(.CNT_W(4))  ifb ();

    assign ifa.id_valid     = id_valid;
    assign ifa.id_opcode    = id_opcode;
    assign ifa.id_rs        = id_rs;
    assign ifa.id_rt        = id_rt;
    assign ifa.id_rd        = id_rd;
    assign ifa.id_reg_write = id_reg_write;
    assign ifa.id_mem_read  = id_mem_read;
    assign ifa.mem_busy     = mem_busy;
    assign ifb.id_valid     = id_valid;
    assign ifb.id_opcode    = id_opcode;
    assign ifb.id_rs        = id_rs;
    assign ifb.id_rt        = id_rt;
    assign ifb.id_rd        = id_rd;
    assign ifb.id_reg_write = id_reg_write;
    assign ifb.id_mem_read  = id_mem_read;
    assign ifb.mem_busy     = mem_busy;

    ex_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    ex_hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic busy);
        id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; mem_busy = busy;
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b1, 6'b000000, rs, rt, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] rs);
        drive(1'b1, 6'b100011, rs, 5'd0, rd, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic nop();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        nop();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 6'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
        #12;
        total++; if (ifa.stall_pc !== 1'b0) begin bad++; $display("FAIL reset_stall_pc got=%0b exp=0", ifa.stall_pc); end
        total++; if (ifa.bubble_idex !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%0b exp=0", ifa.bubble_idex); end
        total++; if (ifa.fwd_a !== 2'b00 || ifa.fwd_b !== 2'b00) begin bad++; $display("FAIL reset_fwd got=%0b/%0b exp=00/00", ifa.fwd_a, ifa.fwd_b); end
        total++; if (ifa.stall_cycles !== 16'd0 || ifa.lu_hazards !== 16'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", ifa.stall_cycles, ifa.lu_hazards); end
        nop();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fwd_ex();
        flush();
        add(5'd3, 5'd1, 5'd2);
        tick();
        add(5'd4, 5'd3, 5'd1);
        #1;
        total++; if (ifa.stall_pc !== 1'b0) begin bad++; $display("FAIL fwd_ex_nostall got=%0b exp=0", ifa.stall_pc); end
        tick();
        total++; if (ifa.fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_ex_a got=%0b exp=10", ifa.fwd_a); end
        total++; if (ifa.fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_ex_b got=%0b exp=00", ifa.fwd_b); end
    endtask

    task automatic test_fwd_mem();
        flush();
        add(5'd3, 5'd1, 5'd1);
        tick();
        nop();
        tick();
        add(5'd6, 5'd1, 5'd3);
        tick();
        total++; if (ifa.fwd_b !== 2'b01) begin bad++; $display("FAIL fwd_mem_b got=%0b exp=01", ifa.fwd_b); end
        total++; if (ifa.fwd_a !== 2'b00) begin bad++; $display("FAIL fwd_mem_a got=%0b exp=00", ifa.fwd_a); end
    endtask

    task automatic test_r0();
        flush();
        add(5'd0, 5'd1, 5'd1);
        tick();
        add(5'd6, 5'd0, 5'd0);
        tick();
        total++; if (ifa.fwd_a !== 2'b00 || ifa.fwd_b !== 2'b00) begin bad++; $display("FAIL r0_fwd got=%0b/%0b exp=00/00", ifa.fwd_a, ifa.fwd_b); end
    endtask

    task automatic test_load_use();
        flush();
        lw(5'd5, 5'd1);
        tick();
        add(5'd7, 5'd5, 5'd2);
        #1;
        total++; if (ifa.stall_pc !== 1'b1 || ifa.stall_ifid !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b/%0b exp=1/1", ifa.stall_pc, ifa.stall_ifid); end
        total++; if (ifa.bubble_idex !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%0b exp=1", ifa.bubble_idex); end
        tick();
        total++; if (ifa.lu_hazards !== 16'd1) begin bad++; $display("FAIL lu_count got=%0d exp=1", ifa.lu_hazards); end
        total++; if (ifa.fwd_a !== 2'b00) begin bad++; $display("FAIL lu_bubble_fwd got=%0b exp=00", ifa.fwd_a); end
        total++; if (ifa.stall_pc !== 1'b0) begin bad++; $display("FAIL lu_release got=%0b exp=0", ifa.stall_pc); end
        tick();
        total++; if (ifa.fwd_a !== 2'b01) begin bad++; $display("FAIL lu_fwd_mem got=%0b exp=01", ifa.fwd_a); end
        total++; if (ifa.stall_cycles !== 16'd1) begin bad++; $display("FAIL lu_stall_cycles got=%0d exp=1", ifa.stall_cycles); end
    endtask

    task automatic test_decode();
        flush();
        lw(5'd5, 5'd1);
        tick();
        drive(1'b1, 6'b101011, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (ifa.stall_pc !== 1'b1) begin bad++; $display("FAIL sw_rt_hazard got=%0b exp=1", ifa.stall_pc); end
        tick();
        lw(5'd5, 5'd1);
        tick();
        drive(1'b1, 6'b001000, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (ifa.stall_pc !== 1'b0) begin bad++; $display("FAIL other_op_nouse got=%0b exp=0", ifa.stall_pc); end
        tick();
    endtask

    task automatic test_mem_wait();
        flush();
        add(5'd3, 5'd1, 5'd1);
        tick();
        add(5'd4, 5'd3, 5'd1);
        tick();
        drive(1'b1, 6'b000000, 5'd4, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ifa.stall_pc !== 1'b1 || ifa.bubble_idex !== 1'b0) begin bad++; $display("FAIL mw_stall%0d got=%0b/%0b exp=1/0", i, ifa.stall_pc, ifa.bubble_idex); end
            tick();
            total++; if (ifa.fwd_a !== 2'b10) begin bad++; $display("FAIL mw_fwd_hold%0d got=%0b exp=10", i, ifa.fwd_a); end
        end
        mem_busy = 1'b0;
        #1;
        total++; if (ifa.stall_pc !== 1'b0) begin bad++; $display("FAIL mw_release got=%0b exp=0", ifa.stall_pc); end
        tick();
        total++; if (ifa.fwd_a !== 2'b10) begin bad++; $display("FAIL mw_shadow_hold got=%0b exp=10", ifa.fwd_a); end
        total++; if (ifa.stall_cycles !== 16'd5) begin bad++; $display("FAIL mw_stall_cycles got=%0d exp=5", ifa.stall_cycles); end
    endtask

    task automatic test_lu_mem_wait();
        flush();
        lw(5'd5, 5'd1);
        tick();
        add(5'd7, 5'd5, 5'd2);
        #1;
        total++; if (ifb.stall_pc !== 1'b1 || ifb.bubble_idex !== 1'b1) begin bad++; $display("FAIL lumw_first got=%0b/%0b exp=1/1", ifb.stall_pc, ifb.bubble_idex); end
        tick();
        mem_busy = 1'b1;
        #1;
        total++; if (ifb.stall_pc !== 1'b1 || ifb.bubble_idex !== 1'b0) begin bad++; $display("FAIL lumw_frozen got=%0b/%0b exp=1/0", ifb.stall_pc, ifb.bubble_idex); end
        tick();
        tick();
        mem_busy = 1'b0;
        #1;
        total++; if (ifb.stall_pc !== 1'b1 || ifb.bubble_idex !== 1'b1) begin bad++; $display("FAIL lumw_second got=%0b/%0b exp=1/1", ifb.stall_pc, ifb.bubble_idex); end
        tick();
        total++; if (ifb.stall_pc !== 1'b0) begin bad++; $display("FAIL lumw_done got=%0b exp=0", ifb.stall_pc); end
        tick();
        total++; if (ifb.fwd_a !== 2'b00) begin bad++; $display("FAIL lumw_fwd got=%0b exp=00", ifb.fwd_a); end
    endtask

    task automatic test_saturation();
        flush();
        mem_busy = 1'b1;
        repeat (20) tick();
        total++; if (ifb.stall_cycles !== 4'hf) begin bad++; $display("FAIL sat_value got=%0d exp=15", ifb.stall_cycles); end
        repeat (2) tick();
        total++; if (ifb.stall_cycles !== 4'hf) begin bad++; $display("FAIL sat_hold got=%0d exp=15", ifb.stall_cycles); end
        mem_busy = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        flush();
        lw(5'd5, 5'd1);
        tick();
        add(5'd7, 5'd5, 5'd2);
        tick();
        reset = 1'b0;
        #1;
        total++; if (ifb.stall_pc !== 1'b0 || ifb.bubble_idex !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl got=%0b/%0b exp=0/0", ifb.stall_pc, ifb.bubble_idex); end
        total++; if (ifb.stall_cycles !== 4'd0 || ifb.lu_hazards !== 4'd0) begin bad++; $display("FAIL rst_mid_counters got=%0d/%0d exp=0/0", ifb.stall_cycles, ifb.lu_hazards); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (ifb.stall_pc !== 1'b0) begin bad++; $display("FAIL rst_mid_run got=%0b exp=0", ifb.stall_pc); end
        tick();
        total++; if (ifb.fwd_a !== 2'b00) begin bad++; $display("FAIL rst_mid_shadow got=%0b exp=00", ifb.fwd_a); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fwd_ex();
        test_fwd_mem();
        test_r0();
        test_load_use();
        test_decode();
        test_mem_wait();
        test_lu_mem_wait();
        test_saturation();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
